// File: rtl/obi_data_initiator.sv
// OBI data-bus initiator: valid/ready command port in, in-order read data /
// write acks out, with credit-bounded transactions in flight and sticky error flags.
module obi_data_initiator #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_we_i,
  input  logic [3:0]               cmd_be_i,
  input  logic [31:0]              cmd_addr_i,
  input  logic [31:0]              cmd_wdata_i,
  output logic                     data_req_o,
  input  logic                     data_gnt_i,
  output logic [31:0]              data_addr_o,
  output logic                     data_we_o,
  output logic [3:0]               data_be_o,
  output logic [31:0]              data_wdata_o,
  input  logic                     data_rvalid_i,
  input  logic [31:0]              data_rdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_we_o,
  output logic [31:0]              rsp_rdata_o,
  output logic [$clog2(DEPTH):0]   outstanding_o,
  output logic                     err_proto_o,
  output logic                     err_timeout_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
  } rsp_t;

  logic [CW-1:0]    credit_q;
  logic [DEPTH-1:0] oq_we;
  logic [PW-1:0]    oq_wr, oq_rd;
  logic [CW-1:0]    oq_cnt;
  rsp_t             rf_mem [DEPTH];
  logic [PW-1:0]    rf_wr, rf_rd;
  logic [CW-1:0]    rf_cnt;
  logic [WW-1:0]    wait_q;

  logic cmd_acc, granted, beat, rsp_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign cmd_ready_o = (!data_req_o | data_gnt_i) & (credit_q < CW'(DEPTH));
  assign cmd_acc     = cmd_valid_i & cmd_ready_o;
  assign granted     = data_req_o & data_gnt_i;
  // A beat with nothing outstanding is a responder error and is dropped.
  assign beat        = data_rvalid_i & (oq_cnt != '0);
  assign rsp_valid_o = (rf_cnt != '0);
  assign rsp_pop     = rsp_valid_o & rsp_ready_i;
  assign rsp_we_o    = rsp_valid_o & rf_mem[rf_rd].we;
  assign rsp_rdata_o = rsp_valid_o ? rf_mem[rf_rd].rdata : '0;
  assign outstanding_o = oq_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_q      <= '0;
      data_req_o    <= 1'b0;
      data_addr_o   <= '0;
      data_we_o     <= 1'b0;
      data_be_o     <= '0;
      data_wdata_o  <= '0;
      oq_we         <= '0;
      oq_wr         <= '0;
      oq_rd         <= '0;
      oq_cnt        <= '0;
      rf_wr         <= '0;
      rf_rd         <= '0;
      rf_cnt        <= '0;
      wait_q        <= '0;
      err_proto_o   <= 1'b0;
      err_timeout_o <= 1'b0;
    end else begin
      // Credit is taken at accept, so the response FIFO cannot overflow.
      credit_q <= credit_q + CW'(cmd_acc) - CW'(rsp_pop);

      if (cmd_acc) begin
        data_req_o   <= 1'b1;
        data_addr_o  <= cmd_addr_i;
        data_we_o    <= cmd_we_i;
        data_be_o    <= cmd_be_i;
        data_wdata_o <= cmd_wdata_i;
      end else if (data_gnt_i) begin
        data_req_o <= 1'b0;
      end

      if (granted) begin
        oq_we[oq_wr] <= data_we_o;
        oq_wr        <= inc(oq_wr);
      end
      if (beat) oq_rd <= inc(oq_rd);
      oq_cnt <= oq_cnt + CW'(granted) - CW'(beat);

      if (beat) begin
        rf_mem[rf_wr] <= '{we: oq_we[oq_rd], rdata: data_rdata_i};
        rf_wr         <= inc(rf_wr);
      end
      if (rsp_pop) rf_rd <= inc(rf_rd);
      rf_cnt <= rf_cnt + CW'(beat) - CW'(rsp_pop);

      if (data_rvalid_i && oq_cnt == '0) err_proto_o <= 1'b1;

      // Wait counter saturates at TIMEOUT; flag sets on the cycle it gets there.
      if (data_req_o && !data_gnt_i) begin
        if (wait_q != WW'(TIMEOUT)) wait_q <= wait_q + WW'(1);
        if (TIMEOUT != 0 && wait_q == WW'(TIMEOUT - 1)) err_timeout_o <= 1'b1;
      end else begin
        wait_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_obi_data_initiator.sv
// Directed bench for obi_data_initiator (DEPTH=4, TIMEOUT=8) with hand-computed expectations.
module tb_obi_data_initiator;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        data_req, data_gnt, data_we;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_be;
  logic        data_rvalid;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic [2:0]  outstanding;
  logic        err_proto, err_timeout;

  int n_chk = 0;
  int n_err = 0;

  obi_data_initiator #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_be_i(cmd_be), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr),
    .data_we_o(data_we), .data_be_o(data_be), .data_wdata_o(data_wdata),
    .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_we_o(rsp_we),
    .rsp_rdata_o(rsp_rdata), .outstanding_o(outstanding),
    .err_proto_o(err_proto), .err_timeout_o(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
    cmd_valid = v; cmd_we = we; cmd_be = be; cmd_addr = a; cmd_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; data_gnt = 0; data_rvalid = 0; data_rdata = '0; rsp_ready = 0;
    set_cmd(0, 0, 4'h0, 32'h0, 32'h0);
    tick(); tick();
    chk("rst_req", {63'd0, data_req}, 64'd0);
    chk("rst_out", {rsp_valid, rsp_we, outstanding, err_proto, err_timeout}, 64'd0);
    chk("rst_fields", {data_addr, data_wdata}, 64'd0);
    chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
    rst = 1'b0;

    // Single load
    set_cmd(1, 0, 4'hF, 32'h100, 32'h0);
    #1 chk("ld_ready", {63'd0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 0; data_gnt = 1;
    #1 chk("ld_req", {27'd0, data_req, data_we, data_be, data_addr}, {27'd0, 1'b1, 1'b0, 4'hF, 32'h100});
    tick();
    data_gnt = 0;
    chk("ld_granted", {60'd0, data_req, outstanding}, {60'd0, 1'b0, 3'd1});
    tick();
    data_rvalid = 1; data_rdata = 32'hDEADBEEF;
    #1 chk("ld_rsp_early", {63'd0, rsp_valid}, 64'd0);
    tick();
    data_rvalid = 0;
    chk("ld_rsp", {rsp_valid, rsp_we, outstanding, rsp_rdata}, {1'b1, 1'b0, 3'd0, 32'hDEADBEEF});
    rsp_ready = 1; tick(); rsp_ready = 0;
    chk("ld_popped", {63'd0, rsp_valid}, 64'd0);

    // Stall stability on a store
    set_cmd(1, 1, 4'h3, 32'h2000, 32'h12345678);
    tick();
    set_cmd(0, 0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("st_hold_ctl", {58'd0, data_req, data_we, data_be}, {58'd0, 1'b1, 1'b1, 4'h3});
      chk("st_hold_dat", {data_addr, data_wdata}, {32'h2000, 32'h12345678});
      tick();
    end
    data_gnt = 1;
    #1 chk("st_gnt_dat", {data_addr, data_wdata}, {32'h2000, 32'h12345678});
    tick();
    data_gnt = 0;
    chk("st_granted", {60'd0, data_req, outstanding}, {60'd0, 1'b0, 3'd1});
    tick();
    data_rvalid = 1; data_rdata = 32'h55;
    tick();
    data_rvalid = 0;
    chk("st_ack", {59'd0, rsp_valid, rsp_we, outstanding}, {59'd0, 1'b1, 1'b1, 3'd0});
    chk("st_no_tmo", {63'd0, err_timeout}, 64'd0);
    rsp_ready = 1; tick(); rsp_ready = 0;

    // Back-to-back and credit limit
    data_gnt = 1;
    for (int i = 0; i < 6; i++) begin
      set_cmd(1, 0, 4'hF, 32'h40 + 32'(4 * ((i < 4) ? i : 4)), 32'h0);
      #1 chk("cr_ready", {63'd0, cmd_ready}, (i < 4) ? 64'd1 : 64'd0);
      if (i >= 1 && i <= 4)
        chk("cr_addr", {32'd0, data_addr}, {32'd0, 32'h40 + 32'(4 * (i - 1))});
      tick();
    end
    set_cmd(0, 0, 4'h0, 32'h0, 32'h0);
    data_gnt = 0;
    #1 chk("cr_out4", {60'd0, data_req, outstanding}, {60'd0, 1'b0, 3'd4});
    for (int i = 0; i < 4; i++) begin
      data_rvalid = 1; data_rdata = 32'h100 + 32'(i);
      tick();
    end
    data_rvalid = 0;
    chk("cr_held", {29'd0, rsp_valid, cmd_ready, outstanding, rsp_rdata}, {29'd0, 1'b1, 1'b0, 3'd0, 32'h100});
    tick();
    chk("cr_stable", {32'd0, rsp_rdata}, {32'd0, 32'h100});
    rsp_ready = 1;
    #1 chk("cr_full_ready", {63'd0, cmd_ready}, 64'd0);
    tick();
    rsp_ready = 0;
    chk("cr_reopen", {31'd0, cmd_ready, rsp_rdata}, {31'd0, 1'b1, 32'h101});
    for (int i = 1; i < 4; i++) begin
      chk("cr_drain", {31'd0, rsp_valid, rsp_rdata}, {31'd0, 1'b1, 32'h100 + 32'(i)});
      rsp_ready = 1; tick(); rsp_ready = 0;
    end
    chk("cr_empty", {63'd0, rsp_valid}, 64'd0);

    // Ordering of mixed loads and stores
    data_gnt = 1;
    set_cmd(1, 0, 4'hF, 32'h10, 32'h0); tick();
    set_cmd(1, 1, 4'hF, 32'h14, 32'h99); tick();
    chk("ord_we", {31'd0, data_we, data_addr}, {31'd0, 1'b1, 32'h14});
    set_cmd(1, 0, 4'hF, 32'h18, 32'h0); tick();
    set_cmd(0, 0, 4'h0, 32'h0, 32'h0); tick();
    data_gnt = 0;
    chk("ord_out", {61'd0, outstanding}, 64'd3);
    data_rvalid = 1; data_rdata = 32'hA; tick();
    data_rdata = 32'hB; tick();
    data_rdata = 32'hC; tick();
    data_rvalid = 0;
    chk("ord_r0", {31'd0, rsp_we, rsp_rdata}, {31'd0, 1'b0, 32'hA});
    rsp_ready = 1; tick();
    chk("ord_r1", {31'd0, rsp_we, rsp_rdata}, {31'd0, 1'b1, 32'hB});
    tick();
    chk("ord_r2", {31'd0, rsp_we, rsp_rdata}, {31'd0, 1'b0, 32'hC});
    tick();
    rsp_ready = 0;
    chk("ord_empty", {63'd0, rsp_valid}, 64'd0);

    // Spurious rvalid
    data_rvalid = 1; data_rdata = 32'hBAD; tick(); data_rvalid = 0;
    chk("proto_set", {60'd0, err_proto, rsp_valid, outstanding[1:0]}, {60'd0, 1'b1, 1'b0, 2'd0});
    tick();
    chk("proto_sticky", {60'd0, err_proto, rsp_valid, outstanding[1:0]}, {60'd0, 1'b1, 1'b0, 2'd0});

    // Grant timeout
    set_cmd(1, 0, 4'hF, 32'h300, 32'h0); tick();
    set_cmd(0, 0, 4'h0, 32'h0, 32'h0);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("tmo_flag", {63'd0, err_timeout}, (j >= 8) ? 64'd1 : 64'd0);
    end
    chk("tmo_req", {31'd0, data_req, data_addr}, {31'd0, 1'b1, 32'h300});

    // Build in-flight state, then reset mid-operation
    data_gnt = 1;
    set_cmd(1, 0, 4'hF, 32'h304, 32'h0); tick();
    set_cmd(1, 0, 4'hF, 32'h308, 32'h0); tick();
    set_cmd(0, 0, 4'h0, 32'h0, 32'h0); tick();
    data_gnt = 0;
    data_rvalid = 1; data_rdata = 32'h77; tick(); data_rvalid = 0;
    chk("pre_rst", {28'd0, rsp_valid, outstanding, rsp_rdata}, {28'd0, 1'b1, 3'd2, 32'h77});
    rst = 1; tick(); rst = 0;
    chk("mid_rst_ctl", {57'd0, data_req, rsp_valid, outstanding, err_proto, err_timeout},
        {57'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
    chk("mid_rst_dat", {rsp_rdata, data_addr}, 64'd0);
    chk("mid_rst_ready", {63'd0, cmd_ready}, 64'd1);
    data_rvalid = 1; tick(); data_rvalid = 0;
    chk("post_rst_proto", {62'd0, err_proto, rsp_valid}, {62'd0, 1'b1, 1'b0});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/obi_data_initiator.md
Name: obi_data_initiator

Overview:
- OBI-style data-bus initiator that drives the same req/gnt/rvalid protocol the core uses toward mm_ram.
- Testbench agents and DMA-like masters use it to issue loads and stores through a simple valid/ready command port.
- It returns read data and write acks in order through a valid/ready response port, with a bounded number of in-flight transactions.
- Protocol violations by the responder are flagged on sticky error outputs.

Parameters:
DEPTH, 4, max transactions in flight (accepted but not yet popped from response port); power of 2, >=1
TIMEOUT, 1024, cycles req may wait for gnt before err_timeout_o sets; 0 disables

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=store, 0=load
cmd_be_i  in  4  byte enables
cmd_addr_i  in  32  byte address
cmd_wdata_i  in  32  store data
data_req_o  out  1  OBI request
data_gnt_i  in  1  OBI grant
data_addr_o  out  32  OBI address
data_we_o  out  1  OBI write enable
data_be_o  out  4  OBI byte enables
data_wdata_o  out  32  OBI write data
data_rvalid_i  in  1  OBI response valid
data_rdata_i  in  32  OBI read data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_we_o  out  1  1=write ack, 0=read data
rsp_rdata_o  out  32  captured data_rdata_i
outstanding_o  out  $clog2(DEPTH)+1  granted, not yet rvalid
err_proto_o  out  1  sticky: rvalid with nothing outstanding
err_timeout_o  out  1  sticky: req waited TIMEOUT cycles

Behaviour:
- Reset (rst_i=1 at posedge):
  - all outputs 0: data_req_o, addr/we/be/wdata, rsp_*, outstanding_o, both err flags.
  - credit counter, order queue and response FIFO emptied.
  - Reset mid-transaction drops all in-flight state. Any rvalid in the first cycle after reset counts as a protocol error.
- Credit counter (0..DEPTH):
  - +1 on cmd accept; -1 on rsp pop; net 0 when both happen in the same cycle.
  - Credit is reserved at accept, so the response FIFO can never overflow.
- Request stage (one pending register):
  - cmd_ready_o = (!data_req_o | data_gnt_i) & (credit < DEPTH). This is combinational from data_gnt_i.
  - On accept, cmd fields are registered into data_* and data_req_o=1 the next cycle. Request latency is 1 cycle.
  - Stability: while data_req_o=1 and data_gnt_i=0, addr/we/be/wdata are held unchanged.
  - On gnt with no new accept, data_req_o drops next cycle.
  - On gnt with a same-cycle accept, back-to-back: data_req_o stays 1 and the fields are loaded with the new cmd.
- Order queue (DEPTH entries, 1 bit we):
  - Push data_we_o on req&gnt; pop on data_rvalid_i.
  - outstanding_o = queue count. Push and pop in the same cycle leaves the count unchanged.
  - rvalid in the same cycle as its own gnt is not legal. rvalid arrives >=1 cycle after gnt, in order.
- Response FIFO (DEPTH entries, {we, rdata}):
  - On data_rvalid_i, push {popped we, data_rdata_i}. rsp_valid_o is asserted the cycle after rvalid at the earliest.
  - rsp_* are held stable while rsp_valid_o & !rsp_ready_i.
  - Pointers wrap modulo DEPTH. Push and pop in the same cycle are allowed in every state, including full and empty.
- Errors:
  - data_rvalid_i while the order queue is empty: set err_proto_o, ignore the beat (no push, no pop).
  - Wait counter increments each cycle with data_req_o & !data_gnt_i, and clears on gnt or when req is low.
  - When the wait counter reaches TIMEOUT (TIMEOUT>0), set err_timeout_o. The request remains asserted.
  - Both error flags clear only on reset.

Test Plan:
- Single load: cmd addr=0x100, we=0, be=0xF; gnt in the first req cycle; rvalid 2 cycles later with rdata=0xDEADBEEF -> rsp_valid_o=1 one cycle after rvalid, rsp_we_o=0, rsp_rdata_o=0xDEADBEEF, outstanding_o back to 0.
- Stall stability: store addr=0x2000, wdata=0x12345678, be=0x3; gnt withheld 5 cycles -> data_* unchanged across all 5 cycles, one transaction granted, one write ack (rsp_we_o=1).
- Back-to-back and credit limit, DEPTH=4: 6 loads with gnt tied 1 and rvalid withheld -> exactly 4 accepted then cmd_ready_o=0, outstanding_o=4. Release rvalid with rsp_ready_i=0 -> 4 responses held in FIFO; popping one re-enables cmd_ready_o.
- Ordering: interleaved load(0x10)/store(0x14)/load(0x18), rvalid rdata 0xA, 0xB, 0xC -> responses in order with we 0,1,0 and rdata 0xA, 0xB, 0xC.
- Errors: rvalid with nothing outstanding -> err_proto_o=1 and no response produced. TIMEOUT=8 with gnt never given -> err_timeout_o=1 on wait cycle 8, data_req_o still 1.
- Reset mid-operation: rst_i=1 with 2 transactions outstanding and 1 response queued -> next cycle all outputs 0, cmd_ready_o=1, credit count 0.
